// File: rtl/tlp_tag_ctrl.sv
// Non-posted tag allocator: lowest-free-tag grants, completion retirement, unexpected-completion flagging.
// Optional per-tag completion timeout is compiled in when TLP_TAG_CPL_TIMEOUT_EN is defined.
module tlp_tag_ctrl #(
    parameter int NUM_TAGS       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    output logic       alloc_gnt,
    output logic [9:0] alloc_tag,
    input  logic       cpl_valid,
    input  logic [9:0] cpl_tag,
    input  logic       cpl_last,
    output logic [8:0] free_cnt,
    output logic       err_unexp_cpl,
    output logic       timeout_valid,
    output logic [9:0] timeout_tag
);

    localparam int TW = $clog2(NUM_TAGS);

    logic [NUM_TAGS-1:0] busy;
    logic [NUM_TAGS-1:0] busy_nxt;
    logic [TW-1:0]       cpl_idx;
    logic [TW-1:0]       gnt_idx;
    logic                cpl_in_range;
    logic                cpl_hit;
    logic                gnt_found;
    logic                grant_now;
    logic [8:0]          busy_cnt;

    assign cpl_in_range = (cpl_tag < 10'(NUM_TAGS));
    assign cpl_idx      = cpl_tag[TW-1:0];
    assign cpl_hit      = cpl_valid && cpl_in_range && busy[cpl_idx];

    // Handshake: alloc_req is a level held by the requester; alloc_gnt pulses for one
    // cycle with alloc_tag, and is never followed by another grant in the next cycle.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = TW'(i);
            end
        end
    end

    assign grant_now = alloc_req && !alloc_gnt && gnt_found;

`ifdef TLP_TAG_CPL_TIMEOUT_EN
    localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_CYCLES);

    logic [15:0]   tmo_cnt [NUM_TAGS];
    logic          exp_found;
    logic [TW-1:0] exp_idx;

    // A tag touched by any completion this cycle is not eligible to expire.
    always_comb begin
        exp_found = 1'b0;
        exp_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (busy[i] && (tmo_cnt[i] == TMO_MAX) &&
                !(cpl_valid && cpl_in_range && (cpl_idx == TW'(i)))) begin
                exp_found = 1'b1;
                exp_idx   = TW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) tmo_cnt[i] <= '0;
            timeout_valid <= 1'b0;
            timeout_tag   <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (!busy[i] || !busy_nxt[i] ||
                    (cpl_valid && cpl_in_range && (cpl_idx == TW'(i))))
                    tmo_cnt[i] <= '0;
                else if (tmo_cnt[i] != TMO_MAX)
                    tmo_cnt[i] <= tmo_cnt[i] + 16'd1;
            end
            timeout_valid <= exp_found;
            timeout_tag   <= exp_found ? 10'(exp_idx) : 10'd0;
        end
    end
`else
    assign timeout_valid = 1'b0;
    assign timeout_tag   = '0;
`endif

    // Grant is chosen from the registered busy vector, so same-cycle frees are not visible to it.
    always_comb begin
        busy_nxt = busy;
        if (cpl_hit && cpl_last) busy_nxt[cpl_idx] = 1'b0;
`ifdef TLP_TAG_CPL_TIMEOUT_EN
        if (exp_found) busy_nxt[exp_idx] = 1'b0;
`endif
        if (grant_now) busy_nxt[gnt_idx] = 1'b1;
        busy_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) busy_cnt = busy_cnt + 9'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= '0;
            alloc_gnt     <= 1'b0;
            alloc_tag     <= '0;
            free_cnt      <= 9'(NUM_TAGS);
            err_unexp_cpl <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            alloc_gnt     <= grant_now;
            alloc_tag     <= grant_now ? 10'(gnt_idx) : 10'd0;
            free_cnt      <= 9'(NUM_TAGS) - busy_cnt;
            err_unexp_cpl <= cpl_valid && !cpl_hit;
        end
    end

endmodule

// File: tb/tb_tlp_tag_ctrl.sv
// Bench for tlp_tag_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
// Timeout scenarios are included when TLP_TAG_CPL_TIMEOUT_EN is defined.
module tb_tlp_tag_ctrl;

    localparam int NT = 32;
    localparam int TO = 1024;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [9:0] alloc_tag;
    logic       cpl_valid;
    logic [9:0] cpl_tag;
    logic       cpl_last;
    logic [8:0] free_cnt;
    logic       err_unexp_cpl;
    logic       timeout_valid;
    logic [9:0] timeout_tag;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    // reference model state: per-tag outstanding flag and age in cycles
    bit m_busy [NT];
    int m_age  [NT];
    bit e_gnt;
    int e_tag;
    bit e_err;
    bit e_tv;
    int e_tt;
    int e_free;

    tlp_tag_ctrl #(.NUM_TAGS(NT), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_tag     (alloc_tag),
        .cpl_valid     (cpl_valid),
        .cpl_tag       (cpl_tag),
        .cpl_last      (cpl_last),
        .free_cnt      (free_cnt),
        .err_unexp_cpl (err_unexp_cpl),
        .timeout_valid (timeout_valid),
        .timeout_tag   (timeout_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 1'b0;
            m_age[i]  = 0;
        end
        e_gnt = 0; e_tag = 0; e_err = 0; e_tv = 0; e_tt = 0; e_free = NT;
    endtask

    task automatic model_step(input bit req, input bit cv, input int ct, input bit cl);
        int  gi;
        int  ei;
        bit  hit;
        gi  = -1;
        ei  = -1;
        hit = cv && (ct < NT) && m_busy[ct];
        if (req && !e_gnt)
            for (int i = 0; i < NT; i++) if (!m_busy[i] && gi < 0) gi = i;
`ifdef TLP_TAG_CPL_TIMEOUT_EN
        for (int i = 0; i < NT; i++)
            if (m_busy[i] && m_age[i] >= TO && !(cv && ct == i) && ei < 0) ei = i;
`endif
        for (int i = 0; i < NT; i++) begin
            if (!m_busy[i]) continue;
            if (hit && ct == i) begin
                m_age[i] = 0;
                if (cl) m_busy[i] = 1'b0;
            end else if (i == ei) begin
                m_busy[i] = 1'b0;
                m_age[i]  = 0;
            end else begin
                m_age[i] = (m_age[i] < TO) ? m_age[i] + 1 : TO;
            end
        end
        if (gi >= 0) begin
            m_busy[gi] = 1'b1;
            m_age[gi]  = 0;
        end
        e_gnt  = (gi >= 0);
        e_tag  = (gi >= 0) ? gi : 0;
        e_err  = cv && !hit;
        e_tv   = (ei >= 0);
        e_tt   = (ei >= 0) ? ei : 0;
        e_free = 0;
        for (int i = 0; i < NT; i++) if (!m_busy[i]) e_free++;
    endtask

    // Entered at a falling edge: drive, advance the model, sample 1 after the rising edge.
    task automatic cycle(input bit req, input bit cv, input int ct, input bit cl);
        alloc_req = req;
        cpl_valid = cv;
        cpl_tag   = 10'(ct);
        cpl_last  = cl;
        model_step(req, cv, ct, cl);
        @(posedge clk);
        #1;
        chk("gnt", 16'(alloc_gnt), 16'(e_gnt));
        if (e_gnt) chk("gnt_tag", 16'(alloc_tag), 16'(e_tag));
        chk("free_cnt", 16'(free_cnt), 16'(e_free));
        chk("err", 16'(err_unexp_cpl), 16'(e_err));
        chk("tmo_valid", 16'(timeout_valid), 16'(e_tv));
        if (e_tv) chk("tmo_tag", 16'(timeout_tag), 16'(e_tt));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        alloc_req = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = '0;
        cpl_last  = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt", 16'(alloc_gnt), 16'd0);
        chk("rst_tag", 16'(alloc_tag), 16'd0);
        chk("rst_free", 16'(free_cnt), 16'(NT));
        chk("rst_err", 16'(err_unexp_cpl), 16'd0);
        chk("rst_tmo_valid", 16'(timeout_valid), 16'd0);
        chk("rst_tmo_tag", 16'(timeout_tag), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int waited;
        int lst[$];
        int tg;
        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // held request: grants every other cycle, tags 0..3
        for (int t = 0; t < 4; t++) exp_q.push_back(16'(t));
        for (int k = 1; k <= 8; k++) begin
            cycle(1, 0, 0, 0);
            chk("seq_gnt", 16'(alloc_gnt), 16'(k % 2));
            if (alloc_gnt && exp_q.size() > 0) chk("seq_tag", 16'(alloc_tag), exp_q.pop_front());
        end
        chk("seq_free", 16'(free_cnt), 16'd28);
        chk("seq_left", 16'(exp_q.size()), 16'd0);
        cycle(0, 0, 0, 0);

        // completion to a never-allocated tag and to an out-of-range tag
        cycle(0, 1, 9, 1);
        chk("unexp_err", 16'(err_unexp_cpl), 16'd1);
        chk("unexp_free", 16'(free_cnt), 16'd28);
        cycle(0, 0, 0, 0);
        chk("unexp_pulse", 16'(err_unexp_cpl), 16'd0);
        cycle(0, 1, 300, 1);
        chk("oor_err", 16'(err_unexp_cpl), 16'd1);

        // exhaust the pool, then free tag 5 and expect it back two cycles later
        waited = 0;
        while (e_free != 0 && waited < 100) begin
            cycle(1, 0, 0, 0);
            waited++;
        end
        chk("full_reached", 16'(free_cnt), 16'd0);
        repeat (4) cycle(1, 0, 0, 0);
        chk("full_nognt", 16'(alloc_gnt), 16'd0);
        cycle(1, 1, 5, 1);
        chk("free5_cnt", 16'(free_cnt), 16'd1);
        chk("free5_nogo", 16'(alloc_gnt), 16'd0);
        cycle(1, 0, 0, 0);
        chk("free5_gnt", 16'(alloc_gnt), 16'd1);
        chk("free5_tag", 16'(alloc_tag), 16'd5);
        cycle(0, 0, 0, 0);
        chk("free5_refull", 16'(free_cnt), 16'd0);

        // reset while 10 tags are outstanding
        do_reset();
        for (int k = 0; k < 19; k++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("mid_free", 16'(free_cnt), 16'd22);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_free", 16'(free_cnt), 16'(NT));
        chk("mid_rst_gnt", 16'(alloc_gnt), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("post_rst_tag", 16'(alloc_tag), 16'd0);
        cycle(0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            lst.delete();
            for (int i = 0; i < NT; i++) if (m_busy[i]) lst.push_back(i);
            if ($urandom_range(0, 3) != 0 && lst.size() > 0)
                tg = lst[$urandom_range(0, lst.size() - 1)];
            else
                tg = $urandom_range(0, 63);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), tg,
                  ($urandom_range(0, 9) < 7));
        end

`ifdef TLP_TAG_CPL_TIMEOUT_EN
        // non-final completion restarts the timer of tag 0
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 498; k++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        waited = 0;
        while (!timeout_valid && waited < 1200) begin
            cycle(0, 0, 0, 0);
            waited++;
        end
        chk("restart_seen", 16'(timeout_valid), 16'd1);
        chk("restart_delay", 16'(waited), 16'(TO + 1));
        chk("restart_tag", 16'(timeout_tag), 16'd0);
        cycle(0, 0, 0, 0);
        chk("restart_free", 16'(free_cnt), 16'(NT));

        // three tags expire and are reported in index order
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
        for (int t = 0; t < 3; t++) exp_q.push_back(16'(t));
        waited = 0;
        while (exp_q.size() > 0 && waited < 1200) begin
            cycle(0, 0, 0, 0);
            if (timeout_valid) chk("multi_tag", 16'(timeout_tag), exp_q.pop_front());
            waited++;
        end
        chk("multi_left", 16'(exp_q.size()), 16'd0);
        cycle(0, 0, 0, 0);
        chk("multi_free", 16'(free_cnt), 16'(NT));
        exp_q.delete();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
